// File: rtl/cpu_types_pkg.sv
// Shared types for the 5-stage pipeline sequencing logic: tracker entries,
// forwarding selects, hazard FSM states and the forwarding match helper.
package cpu_types_pkg;

    // Register index width stored in each tracker entry; the controller's
    // REG_ADDR_W is expected to match this.
    localparam int TRK_REG_W = 5;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        HZ_RUN      = 1'b0,
        HZ_MEM_WAIT = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic                 valid;
        logic [TRK_REG_W-1:0] rs1;
        logic [TRK_REG_W-1:0] rs2;
        logic                 use_rs1;
        logic                 use_rs2;
        logic [TRK_REG_W-1:0] rd;
        logic                 reg_write;
        logic                 mem_read;
        logic                 mem_access;
    } stage_track_t;

    // True when entry e will write register r; x0 never counts as a producer.
    function automatic logic produces(input stage_track_t e,
                                      input logic [TRK_REG_W-1:0] r);
        return e.valid && e.reg_write && (e.rd != '0) && (e.rd == r);
    endfunction

    // MEM beats WB; a load still in MEM has no data yet, so only WB may supply it.
    function automatic fwd_sel_t fwd_pick(input stage_track_t mem_e,
                                          input stage_track_t wb_e,
                                          input logic use_src,
                                          input logic [TRK_REG_W-1:0] src);
        if (use_src && produces(mem_e, src) && !mem_e.mem_read)
            return FWD_EXMEM;
        if (use_src && produces(wb_e, src))
            return FWD_MEMWB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_tracker.sv
// Shadow copy of EX/MEM/WB occupancy: a three-entry shift register that
// advances with the pipeline and can drop the MEM entry on its way to WB.
module hazard_tracker
    import cpu_types_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         advance,
    input  logic         drop_mem,
    input  stage_track_t id_entry,
    output stage_track_t ex_entry,
    output stage_track_t mem_entry,
    output stage_track_t wb_entry
);

    // Invalid entries are all-zero so stale fields can never match downstream.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ex_entry  <= '0;
            mem_entry <= '0;
            wb_entry  <= '0;
        end else if (advance) begin
            wb_entry  <= drop_mem ? '0 : mem_entry;
            mem_entry <= ex_entry;
            ex_entry  <= id_entry;
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Sequencing controller for the in-order IF/ID/EX/MEM/WB pipeline: stalls,
// flushes, EX operand forwarding and the data-memory wait/timeout FSM.
//
// Handshake: dmem_ready is a completion strobe with no request side; while a
// valid memory access sits in MEM, the access completes on the first clk edge
// where dmem_ready is high, and every cycle before that freezes the pipeline.
module pipeline_hazard_controller
    import cpu_types_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  ex_redirect,
    input  logic                  dmem_ready,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  pipe_en,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  mem_fault,
    output logic                  busy
);

    hz_state_t          state, state_nx;
    logic [CNT_W-1:0]   wait_cnt, wait_cnt_nx;
    stage_track_t       ex_e, mem_e, wb_e;
    stage_track_t       id_raw, id_entry;
    logic               mem_busy, timeout, freeze, load_use;
    fwd_sel_t           fwd_a, fwd_b;
    logic               unused_fields;

    always_comb begin
        id_raw            = '0;
        id_raw.valid      = id_valid;
        id_raw.rs1        = TRK_REG_W'(id_rs1);
        id_raw.rs2        = TRK_REG_W'(id_rs2);
        id_raw.use_rs1    = id_use_rs1;
        id_raw.use_rs2    = id_use_rs2;
        id_raw.rd         = TRK_REG_W'(id_rd);
        id_raw.reg_write  = id_reg_write;
        id_raw.mem_read   = id_mem_read;
        id_raw.mem_access = id_mem_read | id_mem_write;
    end

    assign id_entry = (id_valid && !id_ex_bubble) ? id_raw : '0;

    hazard_tracker u_tracker (
        .clk       (clk),
        .reset_n   (reset_n),
        .advance   (pipe_en),
        .drop_mem  (timeout),
        .id_entry  (id_entry),
        .ex_entry  (ex_e),
        .mem_entry (mem_e),
        .wb_entry  (wb_e)
    );

    assign mem_busy = mem_e.valid && mem_e.mem_access && !dmem_ready;
    assign timeout  = (state == HZ_MEM_WAIT) && !dmem_ready &&
                      (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
    // A timed-out access is abandoned, so that cycle behaves as an unfrozen one.
    assign freeze   = mem_busy && !timeout;
    assign load_use = ex_e.valid && ex_e.mem_read && (ex_e.rd != '0) && id_valid &&
                      ((id_use_rs1 && (id_raw.rs1 == ex_e.rd)) ||
                       (id_use_rs2 && (id_raw.rs2 == ex_e.rd)));

    assign fwd_a = fwd_pick(mem_e, wb_e, ex_e.use_rs1, ex_e.rs1);
    assign fwd_b = fwd_pick(mem_e, wb_e, ex_e.use_rs2, ex_e.rs2);

    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        case (state)
            HZ_RUN: begin
                if (mem_busy) begin
                    state_nx    = HZ_MEM_WAIT;
                    wait_cnt_nx = CNT_W'(1);
                end
            end
            HZ_MEM_WAIT: begin
                if (dmem_ready || timeout) begin
                    state_nx    = HZ_RUN;
                    wait_cnt_nx = '0;
                end else begin
                    wait_cnt_nx = wait_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx    = HZ_RUN;
                wait_cnt_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= HZ_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
        end
    end

    // A redirect is honoured on any unfrozen cycle, including the resume edge,
    // because the branch leaves EX on that edge and would otherwise be lost.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_en      = 1'b1;
        fwd_a_sel    = fwd_a;
        fwd_b_sel    = fwd_b;
        mem_fault    = timeout;
        busy         = (state != HZ_RUN);
        if (freeze) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            pipe_en  = 1'b0;
        end else if (ex_redirect) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (load_use) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
        end
        if (!reset_n) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            pipe_en      = 1'b0;
            fwd_a_sel    = FWD_RF;
            fwd_b_sel    = FWD_RF;
            mem_fault    = 1'b0;
            busy         = 1'b0;
        end
    end

    // Tracker fields that only matter in other stages.
    assign unused_fields = ^{ex_e.reg_write, ex_e.mem_access,
                             mem_e.rs1, mem_e.rs2, mem_e.use_rs1, mem_e.use_rs2,
                             wb_e.rs1, wb_e.rs2, wb_e.use_rs1, wb_e.use_rs2,
                             wb_e.mem_read, wb_e.mem_access};

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: a directed walk through
// the hazard scenarios with hand-computed values, then randomized traffic.
module tb_pipeline_hazard_controller;

    localparam int RW = 5;
    localparam int MT = 4;
    localparam int EW = 11;

    logic          clk, reset_n;
    logic          id_valid, id_use_rs1, id_use_rs2;
    logic [RW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_reg_write, id_mem_read, id_mem_write;
    logic          ex_redirect, dmem_ready;
    logic          pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_en;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic          mem_fault, busy;

    pipeline_hazard_controller #(
        .REG_ADDR_W  (RW),
        .MEM_TIMEOUT (MT),
        .CNT_W       (5)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .id_mem_write (id_mem_write),
        .ex_redirect  (ex_redirect),
        .dmem_ready   (dmem_ready),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .if_id_flush  (if_id_flush),
        .id_ex_bubble (id_ex_bubble),
        .pipe_en      (pipe_en),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .mem_fault    (mem_fault),
        .busy         (busy)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    typedef struct {
        bit v;
        int rs1;
        int rs2;
        bit u1;
        bit u2;
        int rd;
        bit rw;
        bit mr;
        bit ma;
    } ins_t;

    typedef struct {
        bit rst_n;
        bit v;
        int rs1;
        int rs2;
        bit u1;
        bit u2;
        int rd;
        bit rw;
        bit mr;
        bit mw;
        bit redir;
        bit rdy;
    } stim_t;

    ins_t m_ex, m_mem, m_wb, nx_ex, nx_mem, nx_wb;
    int   m_wait, nx_wait;   // consecutive frozen cycles of the current MEM access

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] cmp_exp, cmp_act;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    event cmp_ev;

    function automatic ins_t no_ins();
        ins_t e;
        e = '{default: 0};
        return e;
    endfunction

    function automatic bit [1:0] fwd_of(int src, bit use_src, ins_t mem_i, ins_t wb_i);
        if (!use_src) return 2'b00;
        if (mem_i.v && mem_i.rw && !mem_i.mr && mem_i.rd != 0 && mem_i.rd == src) return 2'b01;
        if (wb_i.v && wb_i.rw && wb_i.rd != 0 && wb_i.rd == src) return 2'b10;
        return 2'b00;
    endfunction

    // Expected outputs {pc,if_id_en,flush,bubble,pipe,fwd_a,fwd_b,fault,busy}.
    task automatic model_eval(input stim_t s, output logic [EW-1:0] e);
        bit       stall, tmo, frz, lu;
        bit [4:0] ctl;
        bit [1:0] fa, fb;
        ins_t     idi;
        nx_ex   = m_ex;
        nx_mem  = m_mem;
        nx_wb   = m_wb;
        nx_wait = m_wait;
        if (!s.rst_n) begin
            e       = 11'b00110_00_00_0_0;
            nx_ex   = no_ins();
            nx_mem  = no_ins();
            nx_wb   = no_ins();
            nx_wait = 0;
        end else begin
            stall = m_mem.v && m_mem.ma && !s.rdy;
            tmo   = stall && (m_wait == MT - 1);
            frz   = stall && !tmo;
            lu    = m_ex.v && m_ex.mr && m_ex.rd != 0 && s.v &&
                    ((s.u1 && s.rs1 == m_ex.rd) || (s.u2 && s.rs2 == m_ex.rd));
            if (frz)          ctl = 5'b00000;
            else if (s.redir) ctl = 5'b11111;
            else if (lu)      ctl = 5'b00011;
            else              ctl = 5'b11001;
            fa = fwd_of(m_ex.rs1, m_ex.u1, m_mem, m_wb);
            fb = fwd_of(m_ex.rs2, m_ex.u2, m_mem, m_wb);
            e  = {ctl, fa, fb, tmo, (m_wait != 0)};
            if (ctl[0]) begin
                nx_wb  = tmo ? no_ins() : m_mem;
                nx_mem = m_ex;
                if (s.v && !ctl[1]) begin
                    idi = '{v: 1, rs1: s.rs1, rs2: s.rs2, u1: s.u1, u2: s.u2,
                            rd: s.rd, rw: s.rw, mr: s.mr, ma: (s.mr || s.mw)};
                    nx_ex = idi;
                end else begin
                    nx_ex = no_ins();
                end
            end
            nx_wait = frz ? m_wait + 1 : 0;
        end
    endtask

    // ---------------- stimulus builders ----------------
    function automatic stim_t nop();
        stim_t s;
        s = '{default: 0};
        s.rst_n = 1;
        s.rdy   = 1;
        return s;
    endfunction

    function automatic stim_t rst();
        stim_t s;
        s = nop();
        s.rst_n = 0;
        return s;
    endfunction

    function automatic stim_t alu(int rd, int rs1, bit u1, int rs2, bit u2);
        stim_t s;
        s = nop();
        s.v = 1; s.rd = rd; s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2; s.rw = 1;
        return s;
    endfunction

    function automatic stim_t ld(int rd, int rs1);
        stim_t s;
        s = alu(rd, rs1, 1, 0, 0);
        s.mr = 1;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        int    kind;
        s = nop();
        s.rst_n = ($urandom_range(63) != 0);
        s.v     = ($urandom_range(3) != 0);
        s.rs1   = $urandom_range(7);
        s.rs2   = $urandom_range(7);
        s.u1    = $urandom_range(1);
        s.u2    = $urandom_range(1);
        s.rd    = $urandom_range(7);
        kind    = $urandom_range(3);
        s.mr    = (kind == 0);
        s.mw    = (kind == 1);
        s.rw    = (kind == 0) || ((kind >= 2) && ($urandom_range(3) != 0));
        s.redir = ($urandom_range(7) == 0);
        s.rdy   = ($urandom_range(3) != 0);
        return s;
    endfunction

    // ---------------- driver ----------------
    task automatic cycle(input stim_t s, input bit pin, input logic [EW-1:0] lit);
        logic [EW-1:0] e;
        @(negedge clk);
        reset_n      = s.rst_n;
        id_valid     = s.v;
        id_rs1       = RW'(s.rs1);
        id_rs2       = RW'(s.rs2);
        id_use_rs1   = s.u1;
        id_use_rs2   = s.u2;
        id_rd        = RW'(s.rd);
        id_reg_write = s.rw;
        id_mem_read  = s.mr;
        id_mem_write = s.mw;
        ex_redirect  = s.redir;
        dmem_ready   = s.rdy;
        model_eval(s, e);
        exp_q.push_back(e);
        if (pin) begin
            checks++;
            if (e !== lit) begin
                errors++;
                $display("FAIL model_pin cyc=%0d model=%b hand=%b", cyc, e, lit);
            end
        end
        -> cmp_ev;
        @(posedge clk);
        m_ex   = nx_ex;
        m_mem  = nx_mem;
        m_wb   = nx_wb;
        m_wait = nx_wait;
        cyc++;
    endtask

    task automatic dcyc(input stim_t s, input logic [EW-1:0] lit);
        cycle(s, 1'b1, lit);
    endtask

    // ---------------- scoreboard compare ----------------
    always @(cmp_ev) begin
        #1;
        cmp_act = {pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_en,
                   fwd_a_sel, fwd_b_sel, mem_fault, busy};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL outputs cyc=%0d got=%b expected queue empty", cyc, cmp_act);
        end else begin
            cmp_exp = exp_q.pop_front();
            if (cmp_act !== cmp_exp) begin
                errors++;
                $display("FAIL outputs cyc=%0d got=%b expected=%b (pc,ifid,flush,bub,pipe,fa,fb,fault,busy)",
                         cyc, cmp_act, cmp_exp);
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        stim_t s;
        reset_n = 1'b0; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_reg_write = 1'b0;
        id_mem_read = 1'b0; id_mem_write = 1'b0; ex_redirect = 1'b0; dmem_ready = 1'b1;
        m_ex = no_ins(); m_mem = no_ins(); m_wb = no_ins(); m_wait = 0;

        dcyc(rst(), 11'b00110_00_00_0_0);
        dcyc(rst(), 11'b00110_00_00_0_0);

        // load-use: lw x5 then add x6,x5,x7
        dcyc(ld(5, 1),              11'b11001_00_00_0_0);
        dcyc(alu(6, 5, 1, 7, 1),    11'b00011_00_00_0_0);
        dcyc(alu(6, 5, 1, 7, 1),    11'b11001_00_00_0_0);
        dcyc(nop(),                 11'b11001_10_00_0_0);

        // ALU back-to-back: add x3 then sub x4,x3,x3
        dcyc(alu(3, 1, 1, 2, 1),    11'b11001_00_00_0_0);
        dcyc(alu(4, 3, 1, 3, 1),    11'b11001_00_00_0_0);
        dcyc(nop(),                 11'b11001_01_01_0_0);

        // x0 producers never forward
        dcyc(alu(0, 0, 1, 0, 0),    11'b11001_00_00_0_0);
        dcyc(alu(0, 1, 1, 0, 0),    11'b11001_00_00_0_0);
        dcyc(alu(10, 0, 1, 0, 1),   11'b11001_00_00_0_0);
        dcyc(nop(),                 11'b11001_00_00_0_0);

        // x9 in MEM (ALU) and WB (load): MEM wins
        dcyc(ld(9, 1),              11'b11001_00_00_0_0);
        dcyc(alu(9, 2, 1, 0, 0),    11'b11001_00_00_0_0);
        dcyc(alu(11, 9, 1, 9, 1),   11'b11001_00_00_0_0);
        dcyc(nop(),                 11'b11001_01_01_0_0);

        // redirect collides with load-use
        dcyc(ld(5, 1),              11'b11001_00_00_0_0);
        s = alu(6, 5, 1, 0, 0); s.redir = 1;
        dcyc(s,                     11'b11111_00_00_0_0);
        dcyc(nop(),                 11'b11001_00_00_0_0);

        // MEM wait: dmem_ready low for 3 cycles
        dcyc(ld(7, 1),              11'b11001_00_00_0_0);
        dcyc(nop(),                 11'b11001_00_00_0_0);
        s = nop(); s.rdy = 0;
        dcyc(s,                     11'b00000_00_00_0_0);
        dcyc(s,                     11'b00000_00_00_0_1);
        dcyc(s,                     11'b00000_00_00_0_1);
        dcyc(nop(),                 11'b11001_00_00_0_1);
        dcyc(nop(),                 11'b11001_00_00_0_0);

        // timeout: lw x8 never completes, consumer must not see it forwarded
        dcyc(ld(8, 1),              11'b11001_00_00_0_0);
        dcyc(nop(),                 11'b11001_00_00_0_0);
        s = alu(12, 8, 1, 0, 0); s.rdy = 0;
        dcyc(s,                     11'b00000_00_00_0_0);
        dcyc(s,                     11'b00000_00_00_0_1);
        dcyc(s,                     11'b00000_00_00_0_1);
        dcyc(s,                     11'b11001_00_00_1_1);
        s = nop(); s.rdy = 0;
        dcyc(s,                     11'b11001_00_00_0_0);

        // reset in the middle of a wait
        dcyc(ld(8, 1),              11'b11001_00_00_0_0);
        dcyc(nop(),                 11'b11001_00_00_0_0);
        s = nop(); s.rdy = 0;
        dcyc(s,                     11'b00000_00_00_0_0);
        dcyc(s,                     11'b00000_00_00_0_1);
        s.rst_n = 0;
        dcyc(s,                     11'b00110_00_00_0_0);
        s.rst_n = 1;
        dcyc(s,                     11'b11001_00_00_0_0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(rand_stim(), 1'b0, '0);
        end

        @(negedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d leftover expected=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
